dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory access controller directly downstream of the single-cycle datapath.
- Consumes the datapath's ALU result (byte address), store data and the controller's memread/memwrite strobes.
- Runs a req/ack handshake to a variable-latency data RAM and returns load data to the datapath result mux.
- Asserts stall to freeze PC and register-file write until the access completes.

Parameters:
- TIMEOUT, 15, max cycles in REQ waiting for mem_ack before abort (1..255).
- ERRDATA, 32'hDEAD_BEEF, readdata value returned on timed-out load.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- memread  input  1  load request from main decoder.
- memwrite  input  1  store request from main decoder.
- addr  input  32  byte address (datapath aluout).
- writedata  input  32  store data from register file port 2.
- readdata  output  32  load data to datapath result mux.
- stall  output  1  1 = hold PC, suppress regwrite this cycle.
- misalign  output  1  sticky: access with addr[1:0] != 0 seen.
- timeout  output  1  sticky: access aborted by TIMEOUT.
- mem_req  output  1  request to RAM, registered.
- mem_we  output  1  1 = write, valid while mem_req.
- mem_addr  output  30  word address (addr[31:2]), registered.
- mem_wdata  output  32  write data, registered.
- mem_ack  input  1  RAM completion, one-cycle pulse.
- mem_rdata  input  32  read data, valid with mem_ack on reads.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, readdata, misalign, timeout, wait counter all 0.
  - stall forced 0 while reset is asserted.
- States: IDLE, REQ, DONE.
- IDLE:
  - access = memread | memwrite.
  - If access and addr[1:0]==0: stall=1 (combinational, same cycle). Latch mem_addr=addr[31:2], mem_wdata=writedata, mem_we=memwrite. Set mem_req=1 at the edge. Next state REQ; counter cleared.
  - If access and addr[1:0]!=0: no request, stall=0, misalign set to 1 at the edge, readdata unchanged, stay IDLE.
  - memread and memwrite both 1: write has priority; mem_we=1, readdata not updated.
  - No access: stall=0, outputs hold.
- REQ:
  - stall=1; mem_req, mem_we, mem_addr, mem_wdata held stable.
  - mem_ack=1: mem_req cleared at the edge. If mem_we=0, readdata <= mem_rdata. Next state DONE.
  - Otherwise counter increments. When counter==TIMEOUT-1 and no ack: mem_req cleared, timeout set to 1. If load, readdata <= ERRDATA. Next state DONE.
  - mem_ack and timeout limit in the same cycle: ack wins, timeout not set.
- DONE:
  - stall=0 for exactly one cycle so the instruction retires (regwrite of readdata). Next state IDLE unconditionally.
  - memread/memwrite still asserted in DONE (same instruction) must not start a new access.
- mem_ack outside REQ is ignored.
- Latency:
  - Zero-wait RAM (ack in first REQ cycle): 3 cycles per load/store, stall high for 2 of them.
  - N ack-wait cycles: 3+N cycles.
- readdata is registered and holds its value until the next completed load; it is valid during DONE.
- misalign and timeout are sticky and cleared only by reset.
- Reset asserted mid-REQ: mem_req drops asynchronously; the in-flight RAM transaction is abandoned; a late ack after reset release is ignored because state=IDLE.

Test Plan:
- Aligned load, addr=32'h0000_0044, ack in first REQ cycle with mem_rdata=32'h1234_5678 -> mem_addr=30'h11, mem_we=0; stall=1,1,0 over 3 cycles; readdata=32'h1234_5678 in DONE.
- Store, addr=32'h0000_0080, writedata=32'hCAFE_F00D, ack after 4 wait cycles -> mem_req high 5 cycles, mem_we=1, mem_wdata=32'hCAFE_F00D; stall low only in DONE; readdata unchanged.
- Load at addr=32'h0000_0046 -> mem_req never asserts; stall=0; misalign=1 next cycle and remains 1 after later good accesses.
- Load with mem_ack never asserted, TIMEOUT=15 -> mem_req drops after 15 REQ cycles; timeout=1; readdata=32'hDEAD_BEEF; stall released for one DONE cycle.
- Drive reset=0 mid-REQ (cycle 2 of wait), then ack pulse after release -> mem_req=0 immediately; state IDLE; late ack ignored; all outputs 0.
- memread and memwrite both 1, addr=32'h10 -> write issued (mem_we=1); readdata not updated.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns the datapath's memread/memwrite strobes into a
// req/ack transaction to a variable-latency RAM and stalls the core until it completes.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [31:0] ERRDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misalign,
  output logic        timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic       access, aligned, start, bad, ack_hit, expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    access  = memread | memwrite;
    aligned = (addr[1:0] == 2'b00);
    start   = 1'b0;
    bad     = 1'b0;
    ack_hit = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        start = access & aligned;
        bad   = access & ~aligned;
        if (start) state_d = REQ;
      end
      REQ: begin
        // ack beats the timeout limit when both land on the same cycle
        ack_hit = mem_ack;
        expire  = ~mem_ack & (cnt_q == LIMIT);
        if (ack_hit | expire) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall is combinational so the PC freezes in the same cycle the access is seen.
  assign stall = reset & (start | (state_q == REQ));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      readdata  <= '0;
      misalign  <= 1'b0;
      timeout   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= memwrite;
        mem_addr  <= addr[31:2];
        mem_wdata <= writedata;
        cnt_q     <= '0;
      end
      if (bad) misalign <= 1'b1;
      if (ack_hit) begin
        mem_req <= 1'b0;
        if (!mem_we) readdata <= mem_rdata;
      end else if (expire) begin
        mem_req <= 1'b0;
        timeout <= 1'b1;
        if (!mem_we) readdata <= ERRDATA;
      end else if (state_q == REQ) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one task per scenario, expected values hand-computed.
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, mem_ack;
  logic [31:0] addr, writedata, mem_rdata;
  logic [31:0] readdata, mem_wdata;
  logic [29:0] mem_addr;
  logic        stall, misalign, timeout, mem_req, mem_we;
  int          checks = 0;
  int          errors = 0;

  dmem_ctrl #(.TIMEOUT(15), .ERRDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .addr(addr), .writedata(writedata), .readdata(readdata), .stall(stall),
    .misalign(misalign), .timeout(timeout), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // advance one rising edge, then settle 1 time unit
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; memread = 1'b1; memwrite = 1'b0; mem_ack = 1'b0;
    addr = 32'h0; writedata = 32'h0; mem_rdata = 32'h0;
    #12;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, readdata, misalign, timeout} !== '0) begin
      errors++; $display("FAIL reset_outputs got req=%b we=%b addr=%h wd=%h rd=%h mis=%b to=%b exp all 0",
        mem_req, mem_we, mem_addr, mem_wdata, readdata, misalign, timeout);
    end
    memread = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_load();
    @(negedge clk); memread = 1'b1; addr = 32'h0000_0044; #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL load_stall_c0 got=%b exp=1", stall); end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h11 || stall !== 1'b1) begin
      errors++; $display("FAIL load_req got req=%b we=%b addr=%h stall=%b exp 1 0 11 1", mem_req, mem_we, mem_addr, stall);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checks++;
    if (stall !== 1'b0 || readdata !== 32'h1234_5678 || mem_req !== 1'b0) begin
      errors++; $display("FAIL load_done got stall=%b rd=%h req=%b exp 0 12345678 0", stall, readdata, mem_req);
    end
    // memread still high in DONE must not start another access
    step();
    memread = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL load_no_restart got req=%b exp=0", mem_req); end
  endtask

  task automatic test_misalign();
    @(negedge clk); memread = 1'b1; addr = 32'h0000_0046; #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall got=%b exp=0", stall); end
    step();
    memread = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || misalign !== 1'b1 || readdata !== 32'h1234_5678) begin
      errors++; $display("FAIL mis_flag got req=%b mis=%b rd=%h exp 0 1 12345678", mem_req, misalign, readdata);
    end
  endtask

  task automatic test_store_wait();
    int req_cycles = 0;
    int stall_hi = 0;
    @(negedge clk); memwrite = 1'b1; addr = 32'h0000_0080; writedata = 32'hCAFE_F00D; #1;
    if (stall) stall_hi++;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mem_req === 1'b1) req_cycles++;
      if (stall === 1'b1) stall_hi++;
      if (i == 0) begin
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'hCAFE_F00D || mem_addr !== 30'h20) begin
          errors++; $display("FAIL store_req got we=%b wd=%h addr=%h exp 1 cafef00d 20", mem_we, mem_wdata, mem_addr);
        end
      end
      if (i == 4) mem_ack = 1'b1;
    end
    step();
    mem_ack = 1'b0;
    checks++;
    if (req_cycles != 5 || stall_hi != 6) begin
      errors++; $display("FAIL store_cycles got req=%0d stall=%0d exp 5 6", req_cycles, stall_hi);
    end
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || readdata !== 32'h1234_5678 || misalign !== 1'b1) begin
      errors++; $display("FAIL store_done got stall=%b req=%b rd=%h mis=%b exp 0 0 12345678 1", stall, mem_req, readdata, misalign);
    end
    step();
    memwrite = 1'b0;
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    @(negedge clk); memread = 1'b1; addr = 32'h0000_0100; #1;
    step();
    while (mem_req === 1'b1 && req_cycles < 40) begin
      req_cycles++;
      step();
    end
    checks++;
    if (req_cycles != 15) begin errors++; $display("FAIL timeout_len got=%0d exp=15", req_cycles); end
    checks++;
    if (timeout !== 1'b1 || readdata !== 32'hDEAD_BEEF || stall !== 1'b0) begin
      errors++; $display("FAIL timeout_done got to=%b rd=%h stall=%b exp 1 deadbeef 0", timeout, readdata, stall);
    end
    step();
    memread = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk); memread = 1'b1; addr = 32'h0000_0200; #1;
    step(); step();
    #2 reset = 1'b0; #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rst_async got req=%b stall=%b exp 0 0", mem_req, stall);
    end
    memread = 1'b0;
    @(negedge clk); reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    mem_ack = 1'b0;
    step();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, readdata, misalign, timeout, stall} !== '0) begin
      errors++; $display("FAIL rst_late_ack got req=%b we=%b addr=%h wd=%h rd=%h mis=%b to=%b stall=%b exp all 0",
        mem_req, mem_we, mem_addr, mem_wdata, readdata, misalign, timeout, stall);
    end
  endtask

  task automatic test_rw_priority();
    @(negedge clk); memread = 1'b1; memwrite = 1'b1; addr = 32'h10; writedata = 32'hA5A5_0001; #1;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 30'h4) begin
      errors++; $display("FAIL rw_req got req=%b we=%b addr=%h exp 1 1 4", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    mem_ack = 1'b0;
    checks++;
    if (readdata !== 32'h0 || stall !== 1'b0) begin
      errors++; $display("FAIL rw_done got rd=%h stall=%b exp 0 0", readdata, stall);
    end
    step();
    memread = 1'b0; memwrite = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_misalign();
    test_store_wait();
    test_timeout();
    test_reset_mid_req();
    test_rw_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
